// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command, ALU and response signals of the ALU operation sequencer.
interface alu_op_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_s;
    logic       alu_rw;
    logic [7:0] alu_f;
    logic       alu_zero;
    logic       alu_carry;
    logic       alu_ovf;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic       busy;
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_f, alu_zero, alu_carry, alu_ovf, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_s, alu_rw, rsp_valid, rsp_data, rsp_flags, busy
    );
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_f, alu_zero, alu_carry, alu_ovf, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_s, alu_rw, rsp_valid, rsp_data, rsp_flags, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: FIFO-buffered command sequencer that issues ops to an ALU and returns result and flags.
module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    alu_op_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, RESP = 2'd3;

    logic [19:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic [7:0]    a_r, b_r, data_r;
    logic [3:0]    op_r, flags_r;
    logic          push, pop, head_legal, arith;
    logic [19:0]   head;

    assign head       = mem[rd_ptr];
    assign head_legal = head[3] || head[3:0] == 4'b0000 || head[3:0] == 4'b0001 || head[3:0] == 4'b0011;
    assign arith      = op_r[3:1] == 3'b000;
    assign push       = bus.cmd_valid && bus.cmd_ready;
    assign pop        = state == IDLE && count != '0;

    // ready depends on count only, so a full FIFO never takes a command alongside a pop
    assign bus.cmd_ready = count != (AW+1)'(DEPTH);
    assign bus.alu_a     = a_r;
    assign bus.alu_b     = b_r;
    assign bus.alu_s     = op_r;
    assign bus.alu_rw    = state == ISSUE;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_data  = data_r;
    assign bus.rsp_flags = flags_r;
    assign bus.busy      = state != IDLE || count != '0;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= '0;
            data_r  <= '0;
            flags_r <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            case (state)
                IDLE: if (pop) begin
                    {a_r, b_r, op_r} <= head;
                    state <= head_legal ? ISSUE : RESP;
                    if (!head_legal) begin
                        data_r  <= '0;
                        flags_r <= 4'b1000;
                    end
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    data_r  <= bus.alu_f;
                    flags_r <= {1'b0, arith & bus.alu_ovf, arith & bus.alu_carry, bus.alu_zero};
                    state   <= RESP;
                end
                default: if (bus.rsp_ready) state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed self-checking bench with a registered ALU model.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;

    alu_op_sequencer_if bus ();
    alu_op_sequencer #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // non-arithmetic ops report carry/ovf = 1 so the sequencer's masking is visible
    function automatic logic [10:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        logic [8:0] r;
        logic v;
        r = 9'h100;
        v = 1'b1;
        case (s)
            4'h0: begin r = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'h1: begin r = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'h3: r[7:0] = a;
            4'h8: r[7:0] = a & b;
            4'h9: r[7:0] = a | b;
            4'hA: r[7:0] = a ^ b;
            4'hB: r[7:0] = ~b;
            default: r[7:0] = 8'hA5;
        endcase
        return {v, r[8], r[7:0] == 8'h00, r[7:0]};
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) {bus.alu_ovf, bus.alu_carry, bus.alu_zero, bus.alu_f} <= '0;
        else if (bus.alu_rw) {bus.alu_ovf, bus.alu_carry, bus.alu_zero, bus.alu_f} <= alu_model(bus.alu_a, bus.alu_b, bus.alu_s);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                           output int lat, output int pulses, output logic [7:0] data, output logic [3:0] flags);
        lat = 0;
        pulses = 0;
        data = 8'hEE;
        flags = 4'hE;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_op = op;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            pulses += int'(bus.alu_rw);
            if (bus.rsp_valid) begin
                lat = k;
                data = bus.rsp_data;
                flags = bus.rsp_flags;
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] d;
        logic [3:0] f;
        int         lat;
        int         p;
    } vec_t;

    vec_t vecs [11] = '{
        '{8'h7F, 8'h01, 4'h0, 8'h80, 4'b0100, 4, 1},
        '{8'h05, 8'h05, 4'h1, 8'h00, 4'b0001, 4, 1},
        '{8'hF0, 8'h0F, 4'h8, 8'h00, 4'b0001, 4, 1},
        '{8'h12, 8'h21, 4'h9, 8'h33, 4'b0000, 4, 1},
        '{8'h3C, 8'h00, 4'h3, 8'h3C, 4'b0000, 4, 1},
        '{8'h00, 8'h0F, 4'hB, 8'hF0, 4'b0000, 4, 1},
        '{8'h80, 8'h80, 4'h0, 8'h00, 4'b0111, 4, 1},
        '{8'h01, 8'h02, 4'hF, 8'hA5, 4'b0000, 4, 1},
        '{8'h33, 8'h44, 4'h5, 8'h00, 4'b1000, 2, 0},
        '{8'h33, 8'h44, 4'h2, 8'h00, 4'b1000, 2, 0},
        '{8'h10, 8'h20, 4'h7, 8'h00, 4'b1000, 2, 0}
    };

    logic [7:0] bp_exp [5] = '{8'h1F, 8'h1E, 8'h1D, 8'h1C, 8'h1B};

    initial begin
        int lat, pulses, acc, got;
        logic [7:0] data;
        logic [3:0] flags;
        bus.cmd_valid = 1'b0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_op = '0;
        bus.rsp_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_alu_rw", 32'(bus.alu_rw), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_rsp_flags", 32'(bus.rsp_flags), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_cmd(vecs[i].a, vecs[i].b, vecs[i].op, lat, pulses, data, flags);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_pulses", i), 32'(pulses), 32'(vecs[i].p));
            check($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].d));
            check($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].f));
        end
        @(posedge clk);
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 0);

        bus.rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.cmd_a = 8'(8'h10 + i);
            bus.cmd_b = 8'h0F;
            bus.cmd_op = 4'hA;
            bus.cmd_valid = 1'b1;
            if (bus.cmd_ready) acc++;
            @(posedge clk);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        check("bp_accepted", 32'(acc), 5);
        check("bp_cmd_ready", 32'(bus.cmd_ready), 0);
        repeat (3) @(negedge clk);
        check("bp_hold_valid", 32'(bus.rsp_valid), 1);
        check("bp_hold_data", 32'(bus.rsp_data), 32'h1F);
        check("bp_hold_flags", 32'(bus.rsp_flags), 0);
        bus.rsp_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 40 && got < 5; k++) begin
            if (bus.rsp_valid) begin
                check($sformatf("bp_rsp%0d", got), 32'(bus.rsp_data), 32'(bp_exp[got]));
                got++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("bp_rsp_count", 32'(got), 5);
        repeat (2) @(negedge clk);
        check("bp_busy_after", 32'(bus.busy), 0);

        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.cmd_a = 8'(8'h40 + i);
            bus.cmd_b = 8'h0F;
            bus.cmd_op = 4'h9;
            bus.cmd_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        check("mid_resp_data", 32'(bus.rsp_data), 32'h4F);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_in_issue", 32'(bus.alu_rw), 1);
        check("mid_alu_a", 32'(bus.alu_a), 32'h41);
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("mid_rst_alu_rw", 32'(bus.alu_rw), 0);
        check("mid_rst_alu_a", 32'(bus.alu_a), 0);
        check("mid_rst_alu_b", 32'(bus.alu_b), 0);
        check("mid_rst_alu_s", 32'(bus.alu_s), 0);
        check("mid_rst_rsp_data", 32'(bus.rsp_data), 0);
        check("mid_rst_rsp_flags", 32'(bus.rsp_flags), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        run_cmd(8'h55, 8'h0F, 4'hB, lat, pulses, data, flags);
        check("post_rst_lat", 32'(lat), 4);
        check("post_rst_pulses", 32'(pulses), 1);
        check("post_rst_data", 32'(data), 32'hF0);
        check("post_rst_flags", 32'(flags), 0);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO depth in entries; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_a, cmd_b  input  8 each  command operands.
REQ-007 cmd_op  input  4  ALU select code.
REQ-008 alu_a, alu_b  output  8 each  operands driven to the ALU.
REQ-009 alu_s  output  4  select code driven to the ALU.
REQ-010 alu_rw  output  1  ALU result-register write enable.
REQ-011 alu_f  input  8  ALU registered result.
REQ-012 alu_zero, alu_carry, alu_ovf  input  1 each  ALU flags.
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  downstream accepts the response.
REQ-015 rsp_data  output  8  captured result.
REQ-016 rsp_flags  output  4  captured flags, ordered {illegal, ovf, carry, zero}.
REQ-017 busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-018 The block SHALL buffer commands in a DEPTH-entry FIFO of {a, b, op} with a count register of width log2(DEPTH)+1 and wrap-around pointers.
- cmd_ready = FIFO not full.
- Push on cmd_valid && cmd_ready.
- No pass-through: a full FIFO does not accept a command in the same cycle as a pop.
REQ-019 The FSM SHALL have exactly four states, IDLE, ISSUE, CAPTURE and RESP, with these transitions:
- IDLE with FIFO non-empty: pop the head into the operand registers; go to ISSUE for a legal op, or to RESP for an illegal op.
- ISSUE: always go to CAPTURE.
- CAPTURE: always go to RESP.
- RESP: on rsp_ready, go to IDLE; otherwise stay.
REQ-020 Legal ops SHALL be 0000, 0001, 0011 and 1000-1111; the ops 0010 and 0100-0111 are illegal.
REQ-021 alu_a, alu_b and alu_s SHALL equal the operand registers.
- The operand registers stay stable from ISSUE through the end of RESP.
- They change only on a pop.
REQ-022 alu_rw SHALL be 1 only during ISSUE, giving exactly one pulse per legal command; an illegal command produces no pulse.
REQ-023 Capture in CAPTURE:
- rsp_data <= alu_f; zero <= alu_zero.
- carry <= alu_carry and ovf <= alu_ovf for ops 0000/0001; carry and ovf <= 0 for all other ops.
- illegal <= 0.
REQ-024 An illegal op SHALL set rsp_data = 0x00 and rsp_flags = 4'b1000 on the IDLE->RESP transition.
REQ-025 rsp_valid SHALL equal (state == RESP).
- rsp_data and rsp_flags are held stable while rsp_valid && !rsp_ready.
REQ-026 Latency: a legal command accepted at edge N into an empty, idle block SHALL produce rsp_valid at edge N+4.
- Back-to-back throughput is one response per 4 cycles with rsp_ready held high.
- An illegal command produces rsp_valid at edge N+2.
REQ-027 A push in the same cycle as a pop SHALL leave count unchanged and ordering FIFO-preserved.
REQ-028 Total accepted capacity is DEPTH+1: DEPTH entries in the FIFO plus one in flight.

Reset
REQ-029 While rst is high, the block SHALL asynchronously force:
- state = IDLE; FIFO empty, pointers and count 0.
- operand registers and alu_a/alu_b/alu_s = 0; alu_rw = 0.
- rsp_valid = 0, rsp_data = 0x00, rsp_flags = 0.
- busy = 0; cmd_ready = 1 once the FIFO is cleared.
REQ-030 Reset asserted mid-operation (any state) SHALL discard the in-flight command and all queued commands; no response is produced for them.
REQ-031 After rst deasserts, the first rising edge SHALL accept a command normally.

Verification
REQ-032 ADD: a=0x7F, b=0x01, op=0000, rsp_ready=1 -> one alu_rw pulse; rsp_valid at accept+4; rsp_data=0x80; rsp_flags=4'b0100.
REQ-033 SUB: a=0x05, b=0x05, op=0001 -> rsp_data=0x00, zero=1, illegal=0; AND: a=0xF0, b=0x0F, op=1000 -> rsp_data=0x00, flags=4'b0001.
REQ-034 Backpressure: rsp_ready=0, cmd_valid held high for 6 cycles with ops 1010 -> exactly 5 accepted; cmd_ready=0 afterwards; rsp data stable; then rsp_ready=1 -> 5 responses in push order.
REQ-035 Illegal: op=0101 -> no alu_rw pulse; rsp_data=0x00; rsp_flags=4'b1000; rsp_valid at accept+2.
REQ-036 Reset: rst pulsed during ISSUE with 2 commands queued -> all outputs at REQ-029 values within the same cycle; no responses appear; a subsequent op=1011 with b=0x0F -> rsp_data=0xF0.
